// File: rtl/hist_pkg.sv
// Shared types and constants for the luma histogram block.
package hist_pkg;

  localparam int BIN_COUNT = 256;
  localparam int SAT_MAX   = 65535;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_WAIT_VS,
    ST_ACCUM,
    ST_READOUT
  } hist_state_e;

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port bin storage with a registered read port (block RAM style).
module hist_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Read-first: a read colliding with a write returns the old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/hist_calc.sv
// Per-frame luma histogram: clear, wait for frame start, accumulate pixels
// with a saturating read-modify-write, then hand out bins over a ready/saved link.
module hist_calc
  import hist_pkg::*;
#(
  parameter int COLORDEPTH = $clog2(BIN_COUNT),
  parameter int BIN_WIDTH  = $clog2(SAT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] data_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  output logic [BIN_WIDTH-1:0]  hist_bin_data,
  output logic [COLORDEPTH-1:0] hist_bin_idx,
  output logic                  hist_bin_ready,
  input  logic                  hist_bin_saved,
  output logic                  busy_o
);

  localparam logic [COLORDEPTH-1:0] LAST_BIN = '1;
  localparam logic [BIN_WIDTH-1:0]  BIN_MAX  = '1;

  hist_state_e           state_q, state_d;
  logic [COLORDEPTH-1:0] clr_addr_q, clr_addr_d;
  logic                  vs_q;
  logic                  acc_vld_q, acc_vld_d;
  logic [COLORDEPTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_vld_q, wr_vld_d;
  logic [COLORDEPTH-1:0] wr_addr_q, wr_addr_d;
  logic [BIN_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                  ro_issue_q, ro_issue_d;
  logic                  ro_pend_q, ro_pend_d;
  logic [COLORDEPTH-1:0] ro_idx_q, ro_idx_d;
  logic                  ready_q, ready_d;
  logic [BIN_WIDTH-1:0]  out_data_q, out_data_d;
  logic [COLORDEPTH-1:0] out_idx_q, out_idx_d;

  logic                  vs_rise;
  logic [BIN_WIDTH-1:0]  bin_cur, bin_inc;
  logic                  ram_we;
  logic [COLORDEPTH-1:0] ram_waddr;
  logic [BIN_WIDTH-1:0]  ram_wdata, ram_rdata;

  assign vs_rise = vs_i & ~vs_q;

  // The RAM misses the write landing in the same cycle as its read, so that value is forwarded.
  assign bin_cur = (wr_vld_q && (wr_addr_q == rd_addr_q)) ? wr_data_q : ram_rdata;
  assign bin_inc = (bin_cur == BIN_MAX) ? bin_cur : bin_cur + 1'b1;

  hist_ram #(
    .AW(COLORDEPTH),
    .DW(BIN_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(rd_addr_d),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      vs_q       <= 1'b0;
      acc_vld_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ro_issue_q <= 1'b0;
      ro_pend_q  <= 1'b0;
      ro_idx_q   <= '0;
      ready_q    <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      vs_q       <= vs_i;
      acc_vld_q  <= acc_vld_d;
      rd_addr_q  <= rd_addr_d;
      wr_vld_q   <= wr_vld_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ro_issue_q <= ro_issue_d;
      ro_pend_q  <= ro_pend_d;
      ro_idx_q   <= ro_idx_d;
      ready_q    <= ready_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    acc_vld_d  = 1'b0;
    rd_addr_d  = rd_addr_q;
    wr_vld_d   = acc_vld_q;
    wr_addr_d  = rd_addr_q;
    wr_data_d  = bin_inc;
    ro_issue_d = 1'b0;
    ro_pend_d  = 1'b0;
    ro_idx_d   = ro_idx_q;
    ready_d    = ready_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    ram_we     = acc_vld_q;
    ram_waddr  = rd_addr_q;
    ram_wdata  = bin_inc;

    unique case (state_q)
      ST_CLEAR: begin
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_BIN) begin
          state_d = ST_WAIT_VS;
        end
      end

      ST_WAIT_VS: begin
        if (vs_rise) begin
          state_d = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (dv_i) begin
          acc_vld_d = 1'b1;
          rd_addr_d = data_i;
        end
        if (vs_rise) begin
          state_d    = ST_READOUT;
          ro_issue_d = 1'b1;
          ro_idx_d   = '0;
        end
      end

      ST_READOUT: begin
        if (ro_issue_q) begin
          rd_addr_d = ro_idx_q;
          ro_pend_d = 1'b1;
        end
        if (ro_pend_q) begin
          out_data_d = bin_cur;
          out_idx_d  = rd_addr_q;
          ready_d    = 1'b1;
        end
        // Fetch the next bin in the acknowledge cycle so it is offered two cycles later.
        if (ready_q && hist_bin_saved) begin
          ready_d = 1'b0;
          if (ro_idx_q == LAST_BIN) begin
            state_d = ST_CLEAR;
          end else begin
            ro_idx_d  = ro_idx_q + 1'b1;
            rd_addr_d = ro_idx_q + 1'b1;
            ro_pend_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign hist_bin_data  = out_data_q;
  assign hist_bin_idx   = out_idx_q;
  assign hist_bin_ready = ready_q;
  assign busy_o         = !((state_q == ST_ACCUM) || (state_q == ST_WAIT_VS));

endmodule

// File: tb/tb_hist_calc.sv
// Randomised frames against an array-of-counters histogram model, read back
// through a consumer with random stalls, ignored acknowledges and a mid-readout reset.
module tb_hist_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_i;
  logic        dv_i;
  logic        vs_i;
  logic [15:0] hist_bin_data;
  logic [7:0]  hist_bin_idx;
  logic        hist_bin_ready;
  logic        hist_bin_saved;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int model[256];
  bit inFrame = 1'b0;

  hist_calc dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .dv_i          (dv_i),
    .vs_i          (vs_i),
    .hist_bin_data (hist_bin_data),
    .hist_bin_idx  (hist_bin_idx),
    .hist_bin_ready(hist_bin_ready),
    .hist_bin_saved(hist_bin_saved),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    foreach (model[i]) model[i] = 0;
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] d, input logic vs);
    dv_i   = dv;
    data_i = d;
    vs_i   = vs;
    @(posedge clk);
    #1;
    if (inFrame && dv && model[d] < 65535) model[d]++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
  endtask

  task automatic startFrame();
    resetModel();
    applyStimulus(1'b1, 8'($urandom), 1'b1);
    inFrame = 1'b1;
    checkOutput("busy_accum", 32'(busy_o), 0);
  endtask

  task automatic endFrame(input logic dv, input logic [7:0] d);
    applyStimulus(dv, d, 1'b1);
    inFrame = 1'b0;
    applyStimulus(1'b1, 8'($urandom), 1'b0);
    checkOutput("ro_lat_early", 32'(hist_bin_ready), 0);
    checkOutput("busy_readout", 32'(busy_o), 1);
    applyStimulus(1'b1, 8'($urandom), 1'b1);
    checkOutput("ro_lat_ready", 32'(hist_bin_ready), 1);
  endtask

  task automatic waitClearDone();
    int n = 0;
    while (busy_o && n < 400) begin
      idleCycle();
      n++;
    end
    checkOutput("clear_done", 32'(busy_o), 0);
    checkOutput("clear_len", 32'(n), 256);
  endtask

  task automatic readoutCheck(input int longStallBin, input int abortBin);
    for (int b = 0; b < 256; b++) begin
      checkOutput("bin_idx", 32'(hist_bin_idx), 32'(b));
      checkOutput("bin_data", 32'(hist_bin_data), 32'(model[b]));
      if (b == abortBin) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(hist_bin_ready), 0);
        checkOutput("rst_busy", 32'(busy_o), 1);
        return;
      end
      begin
        int stall;
        stall = (b == longStallBin) ? 20 :
                (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        for (int s = 0; s < stall; s++) begin
          hist_bin_saved = 1'b0;
          idleCycle();
          checkOutput("hold_ready", 32'(hist_bin_ready), 1);
          checkOutput("hold_idx", 32'(hist_bin_idx), 32'(b));
          checkOutput("hold_data", 32'(hist_bin_data), 32'(model[b]));
        end
      end
      hist_bin_saved = 1'b1;
      idleCycle();
      hist_bin_saved = 1'b0;
      checkOutput("ready_drop", 32'(hist_bin_ready), 0);
      if (b == 255) begin
        checkOutput("busy_clear", 32'(busy_o), 1);
        break;
      end
      hist_bin_saved = 1'($urandom_range(0, 1));
      idleCycle();
      hist_bin_saved = 1'b0;
      checkOutput("ready_next", 32'(hist_bin_ready), 1);
    end
  endtask

  task automatic randomFrame(input int npix, input int dvPct);
    startFrame();
    for (int i = 0; i < npix; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      if (int'($urandom_range(0, 99)) < dvPct) applyStimulus(1'b1, d, 1'b0);
      else applyStimulus(1'b0, d, 1'b0);
    end
    endFrame(1'b1, 8'($urandom_range(0, 15)));
  endtask

  initial begin
    rst            = 1'b1;
    dv_i           = 1'b0;
    vs_i           = 1'b0;
    data_i         = '0;
    hist_bin_saved = 1'b0;
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_ready0", 32'(hist_bin_ready), 0);
    checkOutput("rst_data0", 32'(hist_bin_data), 0);
    checkOutput("rst_idx0", 32'(hist_bin_idx), 0);
    checkOutput("rst_busy0", 32'(busy_o), 1);
    rst = 1'b0;

    for (int k = 1; k <= 256; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), (k == 100) ? 1'b1 : 1'b0);
      checkOutput("clr_busy", 32'(busy_o), (k < 256) ? 32'd1 : 32'd0);
      checkOutput("clr_ready", 32'(hist_bin_ready), 0);
    end
    for (int k = 0; k < 5; k++) begin
      idleCycle();
      checkOutput("wait_vs_idle", 32'(busy_o), 0);
    end

    startFrame();
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'd7, 1'b0);
    for (int i = 0; i < 50; i++) applyStimulus(1'b1, 8'd200, 1'b0);
    endFrame(1'b0, 8'd0);
    readoutCheck(-1, -1);
    waitClearDone();

    startFrame();
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    applyStimulus(1'b1, 8'd5, 1'b0);
    applyStimulus(1'b1, 8'd3, 1'b0);
    endFrame(1'b0, 8'd0);
    readoutCheck(10, -1);
    waitClearDone();

    randomFrame(600, 70);
    readoutCheck(-1, -1);
    waitClearDone();

    randomFrame(400, 100);
    readoutCheck(-1, -1);
    waitClearDone();

    startFrame();
    for (int i = 0; i < 70000; i++) applyStimulus(1'b1, 8'd0, 1'b0);
    endFrame(1'b1, 8'd0);
    readoutCheck(-1, -1);
    waitClearDone();

    randomFrame(300, 80);
    readoutCheck(-1, 128);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_ready", 32'(hist_bin_ready), 0);
    rst = 1'b0;
    waitClearDone();
    randomFrame(300, 60);
    readoutCheck(-1, -1);
    waitClearDone();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
